// File: rtl/memory_access_if.sv
// Memory-stage bus between the EX/MEM pipeline register and the M/W stage.
// Carries the M-side control/data inputs, the stall back to upstream and the registered W outputs.
interface memory_access_if;
   logic        regwriteM;
   logic        isloadM;
   logic        memreadM;
   logic        memwriteM;
   logic [4:0]  rdM;
   logic [31:0] pcplus4M;
   logic [31:0] aluresultM;
   logic [31:0] writedataM;
   logic        stallM;
   logic        regwriteW;
   logic        isloadW;
   logic [4:0]  rdW;
   logic [31:0] pcplus4W;
   logic [31:0] aluresultW;
   logic [31:0] readdataW;
   logic        misalignW;

   modport master (
      output regwriteM, isloadM, memreadM, memwriteM,
      output rdM, pcplus4M, aluresultM, writedataM,
      input  stallM,
      input  regwriteW, isloadW, rdW, pcplus4W,
      input  aluresultW, readdataW, misalignW
   );

   modport slave (
      input  regwriteM, isloadM, memreadM, memwriteM,
      input  rdM, pcplus4M, aluresultM, writedataM,
      output stallM,
      output regwriteW, isloadW, rdW, pcplus4W,
      output aluresultW, readdataW, misalignW
   );
endinterface

// File: rtl/memory_access.sv
// Memory stage with a fixed-latency word data memory.
// Stalls upstream while an aligned access is in flight; drops misaligned accesses.
module memory_access #(
   parameter int DEPTH       = 256,
   parameter int MEM_LATENCY = 2
) (
   input logic              clk,
   input logic              rst,
   memory_access_if.slave   bus
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] BUSY = 1'b1;
   localparam logic [3:0] LAT_M1 = 4'(MEM_LATENCY - 1);
   localparam bit MULTI = (MEM_LATENCY > 1);

   logic [0:0]    state;
   logic [3:0]    cnt;
   logic [31:0]   mem [DEPTH];

   logic          access;
   logic          misalign;
   logic          aligned;
   logic          start;
   logic          complete;
   logic [AW-1:0] idx;
   logic          unusedAddr;

   // Decode the access and the FSM's stall/complete conditions
   always_comb begin
      access   = bus.memreadM | bus.memwriteM;
      misalign = access && (bus.aluresultM[1:0] != 2'b00);
      aligned  = access && !misalign;
      idx      = bus.aluresultM[AW+1:2];
      start    = MULTI && (state == IDLE) && aligned;
      complete = ((state == IDLE) && !start)
              || ((state == BUSY) && (cnt == 4'd1));
   end

   // Upper address bits are deliberately ignored: the memory wraps
   assign unusedAddr = ^bus.aluresultM[31:AW+2];

   assign bus.stallM = !rst
      && (start || ((state == BUSY) && (cnt > 4'd1)));

   // Latency FSM
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= 4'd0;
      end else if (state == BUSY) begin
         cnt <= cnt - 4'd1;
         if (cnt == 4'd1)
            state <= IDLE;
      end else if (start) begin
         state <= BUSY;
         cnt   <= LAT_M1;
      end
   end

   // Memory array: stores take effect only on their completion edge
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++)
            mem[i] <= 32'd0;
      end else if (complete && aligned && bus.memwriteM) begin
         mem[idx] <= bus.writedataM;
      end
   end

   // W register: completion result or a bubble while stalled
   always_ff @(posedge clk) begin
      if (rst || !complete) begin
         bus.regwriteW  <= 1'b0;
         bus.isloadW    <= 1'b0;
         bus.rdW        <= 5'd0;
         bus.pcplus4W   <= 32'd0;
         bus.aluresultW <= 32'd0;
         bus.readdataW  <= 32'd0;
         bus.misalignW  <= 1'b0;
      end else begin
         bus.isloadW    <= bus.isloadM;
         bus.rdW        <= bus.rdM;
         bus.pcplus4W   <= bus.pcplus4M;
         bus.aluresultW <= bus.aluresultM;
         bus.misalignW  <= misalign;
         if (misalign && bus.memreadM)
            bus.regwriteW <= 1'b0;
         else
            bus.regwriteW <= bus.regwriteM;
         if (aligned && bus.memreadM && !bus.memwriteM)
            bus.readdataW <= mem[idx];
         else
            bus.readdataW <= 32'd0;
      end
   end
endmodule

// File: tb/tb_memory_access.sv
// Directed testbench for memory_access.
// Two instances: MEM_LATENCY=2 (dut2) and MEM_LATENCY=3 (dut3).
module tb_memory_access;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   memory_access_if bus2 ();
   memory_access_if bus3 ();

   memory_access #(.DEPTH(256), .MEM_LATENCY(2)) dut2 (
      .clk(clk), .rst(rst), .bus(bus2)
   );
   memory_access #(.DEPTH(256), .MEM_LATENCY(3)) dut3 (
      .clk(clk), .rst(rst), .bus(bus3)
   );

   task automatic drive(input int which,
                        input logic rw, input logic il,
                        input logic mr, input logic mw,
                        input logic [4:0] rd,
                        input logic [31:0] pc,
                        input logic [31:0] addr,
                        input logic [31:0] data);
      if (which == 2) begin
         bus2.regwriteM = rw; bus2.isloadM = il;
         bus2.memreadM = mr;  bus2.memwriteM = mw;
         bus2.rdM = rd;       bus2.pcplus4M = pc;
         bus2.aluresultM = addr; bus2.writedataM = data;
      end else begin
         bus3.regwriteM = rw; bus3.isloadM = il;
         bus3.memreadM = mr;  bus3.memwriteM = mw;
         bus3.rdM = rd;       bus3.pcplus4M = pc;
         bus3.aluresultM = addr; bus3.writedataM = data;
      end
   endtask

   task automatic idle(input int which);
      drive(which, 0, 0, 0, 0, 5'd0, 32'd0, 32'd0, 32'd0);
   endtask

   // Called at posedge+1 after drive; returns at posedge+1 after completion
   task automatic waitDone(input int which, output int stalls);
      logic s;
      stalls = 0;
      for (int i = 0; i < 20; i++) begin
         #1;
         s = (which == 2) ? bus2.stallM : bus3.stallM;
         @(posedge clk); #1;
         if (!s) return;
         stalls++;
      end
      checks++; errors++;
      $display("FAIL timeout dut%0d: stallM still high after 20 cycles", which);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(2, 1, 1, 1, 0, 5'd4, 32'h4, 32'h10, 32'h0);
      @(posedge clk); @(posedge clk); #1;
      checks++;
      if (bus2.stallM !== 1'b0) begin
         errors++; $display("FAIL reset_stall: got %b want 0", bus2.stallM);
      end
      checks++;
      if ({bus2.regwriteW, bus2.isloadW, bus2.misalignW, bus2.rdW} !== 8'd0) begin
         errors++; $display("FAIL reset_wctl: got %b want 0",
            {bus2.regwriteW, bus2.isloadW, bus2.misalignW, bus2.rdW});
      end
      checks++;
      if ({bus2.pcplus4W, bus2.aluresultW, bus2.readdataW} !== 96'd0) begin
         errors++; $display("FAIL reset_wdata: got %h want 0",
            {bus2.pcplus4W, bus2.aluresultW, bus2.readdataW});
      end
      checks++;
      if ({bus3.stallM, bus3.regwriteW, bus3.readdataW} !== 34'd0) begin
         errors++; $display("FAIL reset_dut3: got %h want 0",
            {bus3.stallM, bus3.regwriteW, bus3.readdataW});
      end
      idle(2);
      rst = 1'b0;
   endtask

   task automatic test_store_load();
      int st;
      drive(2, 0, 0, 0, 1, 5'd0, 32'h104, 32'h10, 32'hDEADBEEF);
      waitDone(2, st);
      checks++;
      if (st !== 1) begin
         errors++; $display("FAIL store_stalls: got %0d want 1", st);
      end
      checks++;
      if (bus2.readdataW !== 32'd0) begin
         errors++; $display("FAIL store_readdata: got %h want 0", bus2.readdataW);
      end
      drive(2, 1, 1, 1, 0, 5'd5, 32'h108, 32'h10, 32'h0);
      waitDone(2, st);
      checks++;
      if (st !== 1) begin
         errors++; $display("FAIL load_stalls: got %0d want 1", st);
      end
      checks++;
      if (bus2.readdataW !== 32'hDEADBEEF) begin
         errors++; $display("FAIL load_data: got %h want deadbeef", bus2.readdataW);
      end
      checks++;
      if ({bus2.regwriteW, bus2.isloadW, bus2.rdW, bus2.pcplus4W}
          !== {1'b1, 1'b1, 5'd5, 32'h108}) begin
         errors++; $display("FAIL load_ctl: got %b %b %0d %h want 1 1 5 108",
            bus2.regwriteW, bus2.isloadW, bus2.rdW, bus2.pcplus4W);
      end
      idle(2);
   endtask

   task automatic test_misaligned();
      int st;
      drive(2, 1, 0, 0, 1, 5'd0, 32'h0, 32'h11, 32'h12345678);
      #1;
      checks++;
      if (bus2.stallM !== 1'b0) begin
         errors++; $display("FAIL mis_store_stall: got %b want 0", bus2.stallM);
      end
      @(posedge clk); #1;
      checks++;
      if ({bus2.misalignW, bus2.regwriteW, bus2.readdataW} !== {1'b1, 1'b1, 32'd0}) begin
         errors++; $display("FAIL mis_store_w: got %b %b %h want 1 1 0",
            bus2.misalignW, bus2.regwriteW, bus2.readdataW);
      end
      drive(2, 1, 1, 1, 0, 5'd7, 32'h0, 32'h13, 32'h0);
      #1;
      checks++;
      if (bus2.stallM !== 1'b0) begin
         errors++; $display("FAIL mis_load_stall: got %b want 0", bus2.stallM);
      end
      @(posedge clk); #1;
      checks++;
      if ({bus2.misalignW, bus2.regwriteW, bus2.rdW, bus2.readdataW}
          !== {1'b1, 1'b0, 5'd7, 32'd0}) begin
         errors++; $display("FAIL mis_load_w: got %b %b %0d %h want 1 0 7 0",
            bus2.misalignW, bus2.regwriteW, bus2.rdW, bus2.readdataW);
      end
      drive(2, 1, 1, 1, 0, 5'd6, 32'h0, 32'h10, 32'h0);
      waitDone(2, st);
      checks++;
      if ({bus2.misalignW, bus2.readdataW} !== {1'b0, 32'hDEADBEEF}) begin
         errors++; $display("FAIL mis_mem_kept: got %b %h want 0 deadbeef",
            bus2.misalignW, bus2.readdataW);
      end
      idle(2);
   endtask

   task automatic test_both_high();
      int st;
      drive(2, 0, 0, 1, 1, 5'd0, 32'h0, 32'h30, 32'h99);
      waitDone(2, st);
      checks++;
      if ({bus2.readdataW, bus2.regwriteW} !== {32'd0, 1'b0}) begin
         errors++; $display("FAIL both_store: got %h %b want 0 0",
            bus2.readdataW, bus2.regwriteW);
      end
      drive(2, 1, 1, 1, 0, 5'd2, 32'h0, 32'h30, 32'h0);
      waitDone(2, st);
      checks++;
      if (bus2.readdataW !== 32'h99) begin
         errors++; $display("FAIL both_load: got %h want 99", bus2.readdataW);
      end
      idle(2);
   endtask

   task automatic test_wrap();
      int st;
      drive(2, 0, 0, 0, 1, 5'd0, 32'h0, 32'h400, 32'h1);
      waitDone(2, st);
      drive(2, 1, 1, 1, 0, 5'd3, 32'h0, 32'h0, 32'h0);
      waitDone(2, st);
      checks++;
      if (bus2.readdataW !== 32'h1) begin
         errors++; $display("FAIL wrap: got %h want 1", bus2.readdataW);
      end
      idle(2);
   endtask

   task automatic test_alu();
      drive(2, 1, 0, 0, 0, 5'd3, 32'h104, 32'h7, 32'h0);
      #1;
      checks++;
      if (bus2.stallM !== 1'b0) begin
         errors++; $display("FAIL alu_stall: got %b want 0", bus2.stallM);
      end
      @(posedge clk); #1;
      checks++;
      if ({bus2.aluresultW, bus2.regwriteW, bus2.rdW, bus2.pcplus4W, bus2.readdataW}
          !== {32'h7, 1'b1, 5'd3, 32'h104, 32'd0}) begin
         errors++; $display("FAIL alu_w: got %h %b %0d %h %h want 7 1 3 104 0",
            bus2.aluresultW, bus2.regwriteW, bus2.rdW, bus2.pcplus4W, bus2.readdataW);
      end
      idle(2);
   endtask

   task automatic test_back_to_back();
      int  st;
      time t0;
      t0 = $time;
      drive(2, 0, 0, 0, 1, 5'd0, 32'h0, 32'h8, 32'hA);
      waitDone(2, st);
      drive(2, 1, 1, 1, 0, 5'd8, 32'h0, 32'h8, 32'h0);
      waitDone(2, st);
      checks++;
      if (($time - t0) !== 40) begin
         errors++; $display("FAIL b2b_time: got %0t want 40", $time - t0);
      end
      checks++;
      if (bus2.readdataW !== 32'hA) begin
         errors++; $display("FAIL b2b_data: got %h want a", bus2.readdataW);
      end
      idle(2);
   endtask

   task automatic test_latency3();
      int st;
      drive(3, 0, 0, 0, 1, 5'd0, 32'h0, 32'h8, 32'hCAFEF00D);
      waitDone(3, st);
      checks++;
      if (st !== 2) begin
         errors++; $display("FAIL lat3_store_stalls: got %0d want 2", st);
      end
      drive(3, 1, 1, 1, 0, 5'd9, 32'h0, 32'h8, 32'h0);
      #1;
      checks++;
      if (bus3.stallM !== 1'b1) begin
         errors++; $display("FAIL lat3_stall0: got %b want 1", bus3.stallM);
      end
      @(posedge clk); #1;
      checks++;
      if ({bus3.regwriteW, bus3.stallM} !== 2'b01) begin
         errors++; $display("FAIL lat3_bubble1: got %b want 01",
            {bus3.regwriteW, bus3.stallM});
      end
      @(posedge clk); #1;
      checks++;
      if ({bus3.regwriteW, bus3.stallM} !== 2'b00) begin
         errors++; $display("FAIL lat3_bubble2: got %b want 00",
            {bus3.regwriteW, bus3.stallM});
      end
      @(posedge clk); #1;
      checks++;
      if ({bus3.regwriteW, bus3.rdW, bus3.readdataW} !== {1'b1, 5'd9, 32'hCAFEF00D}) begin
         errors++; $display("FAIL lat3_load: got %b %0d %h want 1 9 cafef00d",
            bus3.regwriteW, bus3.rdW, bus3.readdataW);
      end
      idle(3);
   endtask

   task automatic test_reset_abort();
      int st;
      drive(3, 0, 0, 0, 1, 5'd0, 32'h0, 32'h20, 32'h55);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      idle(3);
      #1;
      checks++;
      if (bus3.stallM !== 1'b0) begin
         errors++; $display("FAIL abort_stall: got %b want 0", bus3.stallM);
      end
      @(posedge clk); #1;
      drive(3, 1, 1, 1, 0, 5'd1, 32'h0, 32'h20, 32'h0);
      waitDone(3, st);
      checks++;
      if (bus3.readdataW !== 32'd0) begin
         errors++; $display("FAIL abort_mem: got %h want 0", bus3.readdataW);
      end
      idle(3);
   endtask

   initial begin
      idle(2);
      idle(3);
      test_reset();
      test_store_load();
      test_misaligned();
      test_both_high();
      test_wrap();
      test_alu();
      test_back_to_back();
      test_latency3();
      test_reset_abort();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
